// File: rtl/serial_parallel_converter.sv
// serial_parallel_converter
// Assembles bytes (MSB first) into 32-bit AES column words and presents them
// on a registered valid/ready output. Each word is tagged with its position
// (0..3) inside the 128-bit AES state. Input is stalled only when a finished
// word has nowhere to go.
module serial_parallel_converter (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic [7:0]  data_in,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] parallel_data_out,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [1:0]  word_index,
  output logic        block_last
);

  localparam logic [1:0] LAST_BYTE = 2'd3;
  localparam logic [1:0] LAST_WORD = 2'd3;

  logic [23:0] r_asm;        // first three bytes of the word being built
  logic [1:0]  r_byte_cnt;   // bytes already held in r_asm
  logic [31:0] r_out_data;
  logic        r_out_valid;
  logic [1:0]  r_word_cnt;   // index the next completed word will carry
  logic [1:0]  r_word_index; // index of the word currently presented

  logic w_byte_acc;
  logic w_out_acc;
  logic w_word_load;

  // Only the fourth byte needs room in the output register; it can use the
  // slot being emptied in the same cycle, hence the out_ready term here.
  assign in_ready    = !((r_byte_cnt == LAST_BYTE) && r_out_valid && !out_ready);
  assign w_byte_acc  = in_valid && in_ready;
  assign w_out_acc   = r_out_valid && out_ready;
  assign w_word_load = w_byte_acc && (r_byte_cnt == LAST_BYTE);

  // Input side: shift accepted bytes into the assembly register.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    if (rst) begin
      r_asm      <= '0;
      r_byte_cnt <= '0;
    end else if (clear) begin
      r_byte_cnt <= '0;
    end else if (w_byte_acc) begin
      if (w_word_load) begin
        r_byte_cnt <= '0;
      end else begin
        r_asm      <= {r_asm[15:0], data_in};
        r_byte_cnt <= r_byte_cnt + 2'd1;
      end
    end
  end

  // Output side: load completed words, track block position, drop valid on hand-off.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_data   <= '0;
      r_out_valid  <= 1'b0;
      r_word_cnt   <= '0;
      r_word_index <= '0;
    end else if (clear) begin
      r_out_valid  <= 1'b0;
      r_word_cnt   <= '0;
      r_word_index <= '0;
    end else begin
      if (w_word_load) begin
        r_out_data   <= {r_asm, data_in};
        r_word_index <= r_word_cnt;
        r_word_cnt   <= r_word_cnt + 2'd1;
      end
      // A load in the same cycle as a hand-off keeps valid high: no bubble.
      if (w_word_load) begin
        r_out_valid <= 1'b1;
      end else if (w_out_acc) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign parallel_data_out = r_out_data;
  assign out_valid         = r_out_valid;
  assign word_index        = r_word_index;
  assign block_last        = r_out_valid && (r_word_index == LAST_WORD);

endmodule

// File: tb/tb_serial_parallel_converter.sv
// Testbench for serial_parallel_converter: a queue-based behavioural model is
// compared against the DUT every cycle, with directed scenarios pinned by
// literal expectations and a randomized byte-stream scoreboard.
module tb_serial_parallel_converter;

  logic        clk = 1'b0;
  logic        rst, clear, in_valid, out_ready;
  logic [7:0]  data_in;
  logic        in_ready, out_valid, block_last;
  logic [31:0] parallel_data_out;
  logic [1:0]  word_index;

  serial_parallel_converter dut (
    .clk               (clk),
    .rst               (rst),
    .clear             (clear),
    .data_in           (data_in),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .parallel_data_out (parallel_data_out),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .word_index        (word_index),
    .block_last        (block_last)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [31:0] data;
    logic [1:0]  idx;
    logic        bl;
  } word_t;

  word_t      delivered[$];   // every word handed off to the consumer
  logic [7:0] partial[$];     // model: bytes of the word under construction
  logic [7:0] sb[$];          // scoreboard: accepted, not yet delivered bytes
  logic [31:0] m_pdata = '0;
  bit          m_valid = 1'b0;
  logic [1:0]  m_idx   = '0;
  int          m_words = 0;   // words formed since last reset/clear

  bit chk_en = 1'b0;
  bit sb_en  = 1'b0;
  int ovalid_cnt = 0;
  int nrdy_cnt   = 0;

  // Compare DUT to model at the falling edge, then advance the model with the
  // inputs that the next rising edge will sample.
  always @(negedge clk) begin : compare
    bit          m_ready;
    logic [31:0] exp_w;
    m_ready = !(partial.size() == 3 && m_valid && !out_ready);
    if (chk_en) begin
      check("in_ready",   {31'b0, in_ready},   {31'b0, m_ready});
      check("out_valid",  {31'b0, out_valid},  {31'b0, m_valid});
      check("pdata",      parallel_data_out,   m_pdata);
      check("word_index", {30'b0, word_index}, {30'b0, m_idx});
      check("block_last", {31'b0, block_last}, {31'b0, (m_valid && m_idx == 2'd3)});
      if (out_valid) ovalid_cnt++;
      if (!in_ready) nrdy_cnt++;
      if (out_valid && out_ready && !rst && !clear) begin
        delivered.push_back('{parallel_data_out, word_index, block_last});
        if (sb_en) begin
          if (sb.size() < 4) begin
            check("sb_underflow", sb.size(), 4);
          end else begin
            exp_w = {sb[0], sb[1], sb[2], sb[3]};
            repeat (4) void'(sb.pop_front());
            check("sb_word", parallel_data_out, exp_w);
          end
        end
      end
      if (rst || clear) sb.delete();
      else if (sb_en && in_valid && in_ready) sb.push_back(data_in);
    end
    // Model step
    if (rst) begin
      partial.delete();
      m_pdata = '0; m_valid = 1'b0; m_idx = '0; m_words = 0;
    end else if (clear) begin
      partial.delete();
      m_valid = 1'b0; m_idx = '0; m_words = 0;
    end else begin
      if (in_valid && m_ready) begin
        partial.push_back(data_in);
        if (partial.size() == 4) begin
          m_pdata = {partial[0], partial[1], partial[2], partial[3]};
          m_idx   = 2'(m_words % 4);
          m_words++;
          partial.delete();
          m_valid = 1'b1;
        end else if (m_valid && out_ready) begin
          m_valid = 1'b0;
        end
      end else if (m_valid && out_ready) begin
        m_valid = 1'b0;
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    data_in  = b;
    in_valid = 1'b1;
    cyc();
  endtask

  logic [31:0] t1_exp[4] = '{32'h00010203, 32'h04050607, 32'h08090A0B, 32'h0C0D0E0F};
  logic [7:0]  t3_bytes[4] = '{8'h11, 8'h22, 8'h33, 8'h44};

  initial begin
    int base_d, base_ov, base_nr, acc, cycles;
    rst = 1'b1; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0; data_in = '0;
    cyc(); cyc();
    rst = 1'b0; chk_en = 1'b1;
    check("rst_out_valid", {31'b0, out_valid}, 0);
    check("rst_in_ready",  {31'b0, in_ready}, 1);
    check("rst_pdata",     parallel_data_out, 0);
    check("rst_idx",       {30'b0, word_index}, 0);
    check("rst_bl",        {31'b0, block_last}, 0);

    // 1: continuous stream 00..0F with out_ready high
    out_ready = 1'b1;
    base_d = delivered.size(); base_ov = ovalid_cnt; base_nr = nrdy_cnt;
    for (int i = 0; i < 16; i++) begin
      send(8'(i));
      if (i == 3) begin
        check("t1_latency_valid", {31'b0, out_valid}, 1);
        check("t1_latency_data",  parallel_data_out, 32'h00010203);
      end
    end
    in_valid = 1'b0;
    cyc(); cyc();
    check("t1_count", delivered.size() - base_d, 4);
    for (int k = 0; k < 4; k++) begin
      if (delivered.size() > base_d + k) begin
        check("t1_word", delivered[base_d + k].data, t1_exp[k]);
        check("t1_idx",  {30'b0, delivered[base_d + k].idx}, k);
        check("t1_bl",   {31'b0, delivered[base_d + k].bl}, (k == 3) ? 1 : 0);
      end
    end
    check("t1_never_stalled", nrdy_cnt - base_nr, 0);
    check("t1_valid_pulses",  ovalid_cnt - base_ov, 4);

    // 2: backpressure with AA..B1
    out_ready = 1'b0;
    base_d = delivered.size();
    for (int i = 0; i < 7; i++) send(8'(8'hAA + i));
    data_in = 8'hB1;
    check("t2_ready_low", {31'b0, in_ready}, 0);
    cyc();
    check("t2_ready_low2", {31'b0, in_ready}, 0);
    check("t2_hold_valid", {31'b0, out_valid}, 1);
    check("t2_hold_data",  parallel_data_out, 32'hAAABACAD);
    check("t2_hold_idx",   {30'b0, word_index}, 0);
    out_ready = 1'b1;
    #1;
    check("t2_ready_comb", {31'b0, in_ready}, 1);
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b0;
    #1;
    check("t2_next_valid", {31'b0, out_valid}, 1);
    check("t2_next_data",  parallel_data_out, 32'hAEAFB0B1);
    check("t2_next_idx",   {30'b0, word_index}, 1);
    check("t2_first_delivered", delivered.size() - base_d, 1);
    out_ready = 1'b1;
    cyc();

    // 3: gapped input
    base_d = delivered.size(); base_ov = ovalid_cnt;
    foreach (t3_bytes[k]) begin
      send(t3_bytes[k]);
      in_valid = 1'b0;
      cyc(); cyc();
    end
    cyc();
    check("t3_count", delivered.size() - base_d, 1);
    if (delivered.size() > base_d) begin
      check("t3_word", delivered[base_d].data, 32'h11223344);
      check("t3_idx",  {30'b0, delivered[base_d].idx}, 2);
    end
    check("t3_valid_cycles", ovalid_cnt - base_ov, 1);

    // 4: clear with a partial word and a pending word
    out_ready = 1'b0;
    base_d = delivered.size();
    for (int i = 1; i <= 4; i++) send(8'(i));
    send(8'hDE); send(8'hAD);
    clear = 1'b1; data_in = 8'hFF; in_valid = 1'b1;
    cyc();
    clear = 1'b0; in_valid = 1'b0;
    #1;
    check("t4_valid", {31'b0, out_valid}, 0);
    check("t4_idx",   {30'b0, word_index}, 0);
    check("t4_ready", {31'b0, in_ready}, 1);
    check("t4_bl",    {31'b0, block_last}, 0);
    out_ready = 1'b1;
    send(8'hBE); send(8'hEF); send(8'h01); send(8'h02);
    in_valid = 1'b0;
    cyc(); cyc();
    check("t4_count", delivered.size() - base_d, 1);
    if (delivered.size() > base_d) begin
      check("t4_word", delivered[base_d].data, 32'hBEEF0102);
      check("t4_idx0", {30'b0, delivered[base_d].idx}, 0);
    end

    // 5: reset mid-block
    for (int i = 0; i < 8; i++) send(8'(8'h60 + i));
    in_valid = 1'b0;
    cyc();
    check("t5_pre_idx", {30'b0, delivered[delivered.size() - 1].idx}, 2);
    send(8'h68); send(8'h69);
    rst = 1'b1; data_in = 8'h55; in_valid = 1'b1;
    cyc();
    rst = 1'b0; in_valid = 1'b0;
    #1;
    check("t5_valid", {31'b0, out_valid}, 0);
    check("t5_ready", {31'b0, in_ready}, 1);
    check("t5_bl",    {31'b0, block_last}, 0);
    check("t5_pdata", parallel_data_out, 0);
    base_d = delivered.size();
    for (int i = 0; i < 4; i++) send(8'(8'h70 + i));
    in_valid = 1'b0;
    cyc(); cyc();
    check("t5_count", delivered.size() - base_d, 1);
    if (delivered.size() > base_d) begin
      check("t5_word", delivered[base_d].data, 32'h70717273);
      check("t5_idx",  {30'b0, delivered[base_d].idx}, 0);
    end

    // 6: random traffic, 1000 bytes, byte-stream scoreboard
    sb.delete();
    sb_en = 1'b1;
    base_d = delivered.size();
    acc = 0; cycles = 0;
    while (acc < 1000 && cycles < 20000) begin
      data_in   = 8'($urandom);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      @(negedge clk);
      if (in_valid && in_ready) acc++;
      @(posedge clk); #1;
      cycles++;
    end
    check("t6_budget", acc, 1000);
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) cyc();
    check("t6_sb_empty", sb.size(), 0);
    check("t6_count", delivered.size() - base_d, 250);
    for (int k = base_d + 1; k < delivered.size(); k++)
      check("t6_idx_step", {30'b0, delivered[k].idx}, {30'b0, 2'(delivered[k - 1].idx + 2'd1)});

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_parallel_converter.md
# serial_parallel_converter

Byte-to-word assembler for the 8-bit AES datapath; the receive-side counterpart of the parallel-to-serial unloader. It collects bytes arriving one per cycle, most significant byte first, into 32-bit column words. It presents each word on a registered valid/ready output and tracks the word's position within the 128-bit AES state (4 words per block). Input backpressure applies only when a completed word cannot be handed off.

## Interface
Parameters: none (byte width 8, word width 32, 4 words per block are fixed).

- clk  input  1  system clock, all logic on rising edge
- rst  input  1  reset; synchronous, active-high (already decided)
- clear  input  1  synchronous flush of partial word, pending output word and word index
- data_in  input  8  incoming byte
- in_valid  input  1  data_in is valid this cycle
- in_ready  output  1  block accepts data_in this cycle (combinational)
- parallel_data_out  output  32  assembled word, first-received byte in [31:24]
- out_valid  output  1  parallel_data_out holds an unconsumed word (registered)
- out_ready  input  1  consumer accepts parallel_data_out this cycle
- word_index  output  2  position (0..3) of the presented word within the current 128-bit block
- block_last  output  1  out_valid && word_index==3 (combinational)

## Operation
- Byte accept: in_valid && in_ready. Output accept: out_valid && out_ready.
- State: 24-bit assembly register asm, 2-bit byte_cnt, 32-bit output register, out_valid flag, 2-bit word_cnt.
- in_ready = !(byte_cnt==3 && out_valid && !out_ready). Bytes 0..2 of a word are always accepted. Byte 3 is accepted only if the output register is empty or is being consumed in the same cycle.
- Byte accept with byte_cnt<3: asm <= {asm[15:0], data_in}; byte_cnt += 1.
- Byte accept with byte_cnt==3:
  - parallel_data_out <= {asm, data_in}; out_valid <= 1; byte_cnt <= 0.
  - word_index <= word_cnt; word_cnt <= word_cnt+1, wrapping 3->0.
- Output accept without a simultaneous word load: out_valid <= 0. parallel_data_out and word_index hold their last values.
- Output accept with a simultaneous word load: the new word replaces the old one and out_valid stays 1. No bubble, no loss.
- in_valid low: no state change on the input side. Bytes may arrive with arbitrary gaps.
- clear (priority over every other input in the same cycle):
  - byte_cnt <= 0, word_cnt <= 0, out_valid <= 0, word_index <= 0.
  - asm and parallel_data_out are not required to be cleared.
  - The byte presented in the clear cycle is discarded.
- rst: all registers to 0; overrides clear.
- Reset/clear values seen at the outputs:
  - parallel_data_out 0 after rst (unchanged after clear).
  - out_valid 0, word_index 0, block_last 0.
  - in_ready 1.
- Reset or clear mid-word: the partial bytes are dropped. The next accepted byte becomes byte 0 (MSB) of a new word.
- Reset or clear with a word pending: the word is dropped and is never presented.

## Timing
- Latency: the 4th byte accepted on edge N gives out_valid=1 with the word visible after edge N, i.e. in cycle N+1.
- Throughput: 1 byte/cycle sustained. A continuous stream with out_ready held at 1 yields one word every 4 cycles, never deasserts in_ready, and out_valid pulses for 1 cycle per word.
- Backpressure: with out_ready low, up to 3 further bytes are absorbed. in_ready then drops while byte_cnt==3. in_ready returns high in the same cycle that out_ready rises (combinational path out_ready->in_ready).
- out_valid, parallel_data_out and word_index are stable while out_valid && !out_ready.
- No combinational path from data_in or in_valid to any output.

## Test plan
- Reset then stream 00..0F, one per cycle, out_ready=1 -> words 00010203, 04050607, 08090A0B, 0C0D0E0F, each 1 cycle after its 4th byte; word_index 0,1,2,3; block_last only on 0C0D0E0F; in_ready constantly 1.
- out_ready=0, send 8 bytes AA..B1 with in_valid held -> 0xAAABACAD presented and held; in_ready low on the cycle offering B1. Raise out_ready -> B1 accepted the same cycle; next cycle presents 0xAEAFB0B1 with word_index 1.
- Gapped input: bytes 11,22,33,44 with 2 idle cycles between each -> single word 0x11223344, out_valid exactly 1 cycle (out_ready=1).
- clear after 2 bytes (DE,AD) and with a pending unconsumed word, then bytes BE,EF,01,02 -> pending word never accepted; next word 0xBEEF0102 with word_index 0.
- rst asserted mid-block (after word_index 2) together with in_valid -> next cycle out_valid=0, in_ready=1, block_last=0; the following 4 bytes produce word_index 0.
- Random in_valid/out_ready over 1000 bytes, compared against a reference queue model -> no lost, duplicated or reordered bytes; word_index increments mod 4 per delivered word.
